spi_slave_fifo_sync: RTL

- Second-generation Wishbone-attached SPI slave. SCLK and SS are oversampled in the wb_clk_i domain, so there are no SCLK-clocked flops.
- Character length is programmable up to DATA_W. MSB-first or LSB-first and the sample/shift edge are selectable.
- Parametrised TX and RX FIFOs, with sticky overrun/underrun flags and a level interrupt.
- Sits between the SPI pads and the Wishbone fabric, in place of the single-register slave.

---
 rtl/spi_slave_pkg.sv | 31 +++
 rtl/spi_sync_fifo.sv | 46 ++++
 rtl/spi_slave_fifo_sync.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_pkg.sv
// Shared register map, control/status bit positions and FSM encoding for the
// oversampled Wishbone SPI slave.
package spi_slave_pkg;

    localparam logic [2:0] REG_RXDATA = 3'd0;
    localparam logic [2:0] REG_TXDATA = 3'd1;
    localparam logic [2:0] REG_CTRL   = 3'd2;
    localparam logic [2:0] REG_STATUS = 3'd3;

    localparam int CTRL_CHAR_LEN   = 0;
    localparam int CTRL_RX_NEGEDGE = 8;
    localparam int CTRL_TX_NEGEDGE = 9;
    localparam int CTRL_LSB_FIRST  = 10;
    localparam int CTRL_IE_RX      = 11;
    localparam int CTRL_IE_ERR     = 12;

    localparam int STAT_RX_EMPTY   = 0;
    localparam int STAT_RX_FULL    = 1;
    localparam int STAT_TX_EMPTY   = 2;
    localparam int STAT_TX_FULL    = 3;
    localparam int STAT_RX_OVERRUN = 4;
    localparam int STAT_TX_UNDERRUN = 5;
    localparam int STAT_BUSY       = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; a push on a full FIFO is accepted
// only when a pop frees the slot in the same cycle.
module spi_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/spi_slave_fifo_sync.sv
// Wishbone SPI slave: SCLK/SS/MOSI oversampled in the wb_clk_i domain,
// programmable character framing, TX/RX FIFOs with sticky error flags.
module spi_slave_fifo_sync
    import spi_slave_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int SS_NB      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CLEN_W     = 5
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [4:0]        wb_adr_i,
    input  logic [DATA_W-1:0] wb_dat_i,
    output logic [DATA_W-1:0] wb_dat_o,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic              wb_int_o,
    input  logic [SS_NB-1:0]  ss_pad_i,
    input  logic              sclk_pad_i,
    input  logic              mosi_pad_i,
    output logic              miso_pad_o
);

    localparam int CNT_W = CLEN_W + 1;

    state_t            state;
    logic [CNT_W-1:0]  bitcnt;
    logic [DATA_W-1:0] rx_sr;
    logic [DATA_W-1:0] tx_sr;

    logic [CLEN_W-1:0] ctrl_len;
    logic              rx_negedge, tx_negedge, lsb_first, ie_rx, ie_err;
    logic              rx_overrun, tx_underrun;

    logic sclk_p0, sclk_p1, sclk_p2;
    logic sel_p0, sel_p1, sel_p2;
    logic mosi_p0, mosi_p1;

    logic [DATA_W-1:0] rx_dout, tx_dout, tx_load, rx_nxt, tx_nxt;
    logic              rx_full, rx_empty, tx_full, tx_empty;
    logic              rx_pop, tx_push, tx_pop, rx_done;

    logic [CNT_W-1:0]  clen, bitcnt_nxt;
    logic [CLEN_W-1:0] msb_idx;
    logic              sclk_rise, sclk_fall, sel_rise, sample_edge, shift_edge, busy;

    logic              acc_start, adr_ok, rd_go, wr_go;
    logic [2:0]        reg_sel;
    logic [DATA_W-1:0] ctrl_rd, status_rd, rd_mux;
    logic              unused_bits;

    function automatic logic active_bit(input logic [DATA_W-1:0] v, input logic lsb,
                                        input logic [CLEN_W-1:0] idx);
        return lsb ? v[0] : v[idx];
    endfunction

    assign unused_bits = ^{wb_adr_i[1:0], wb_sel_i[3:2]};

    // Pad synchronisers (p0/p1) plus one history stage (p2) for edge detect
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            {sclk_p0, sclk_p1, sclk_p2} <= '0;
            {sel_p0, sel_p1, sel_p2}    <= '0;
            {mosi_p0, mosi_p1}          <= '0;
        end else begin
            sclk_p0 <= sclk_pad_i;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            sel_p0  <= ~&ss_pad_i;
            sel_p1  <= sel_p0;
            sel_p2  <= sel_p1;
            mosi_p0 <= mosi_pad_i;
            mosi_p1 <= mosi_p0;
        end
    end

    assign sclk_rise   = sclk_p1 & ~sclk_p2;
    assign sclk_fall   = ~sclk_p1 & sclk_p2;
    assign sel_rise    = sel_p1 & ~sel_p2;
    assign sample_edge = rx_negedge ? sclk_fall : sclk_rise;
    assign shift_edge  = tx_negedge ? sclk_fall : sclk_rise;
    assign busy        = (state != IDLE);

    assign clen       = (ctrl_len == '0) ? CNT_W'(DATA_W) : {1'b0, ctrl_len};
    assign msb_idx    = CLEN_W'(clen - CNT_W'(1));
    assign bitcnt_nxt = bitcnt + CNT_W'(1);
    assign tx_load    = tx_empty ? '0 : tx_dout;
    assign tx_nxt     = lsb_first ? (tx_sr >> 1) : (tx_sr << 1);

    always_comb begin
        rx_nxt = '0;
        if (lsb_first) begin
            rx_nxt          = rx_sr >> 1;
            rx_nxt[msb_idx] = mosi_p1;
        end else begin
            rx_nxt = {rx_sr[DATA_W-2:0], mosi_p1};
        end
    end

    assign tx_pop  = (state == LOAD) & sel_p1 & ~tx_empty;
    assign rx_done = (state == SHIFT) & sel_p1 & sample_edge & (bitcnt_nxt == clen);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            bitcnt     <= '0;
            rx_sr      <= '0;
            tx_sr      <= '0;
            miso_pad_o <= 1'b0;
        end else if (!sel_p1) begin
            // Deselect aborts any partial character without pushing it
            state      <= IDLE;
            bitcnt     <= '0;
            miso_pad_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_rise) state <= LOAD;
                end
                LOAD: begin
                    tx_sr      <= tx_load;
                    rx_sr      <= '0;
                    bitcnt     <= '0;
                    miso_pad_o <= active_bit(tx_load, lsb_first, msb_idx);
                    state      <= SHIFT;
                end
                SHIFT: begin
                    if (sample_edge) begin
                        rx_sr  <= rx_nxt;
                        bitcnt <= bitcnt_nxt;
                    end
                    if (shift_edge) begin
                        tx_sr      <= tx_nxt;
                        miso_pad_o <= active_bit(tx_nxt, lsb_first, msb_idx);
                    end
                    if (rx_done) state <= LOAD;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign acc_start = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign adr_ok    = ~wb_adr_i[4];
    assign reg_sel   = wb_adr_i[4:2];
    assign rd_go     = acc_start & adr_ok & ~wb_we_i;
    assign wr_go     = acc_start & adr_ok & wb_we_i;
    assign rx_pop    = rd_go & (reg_sel == REG_RXDATA) & ~rx_empty;
    assign tx_push   = wr_go & (reg_sel == REG_TXDATA);

    always_comb begin
        ctrl_rd                         = '0;
        ctrl_rd[CLEN_W-1:0]             = ctrl_len;
        ctrl_rd[CTRL_RX_NEGEDGE]        = rx_negedge;
        ctrl_rd[CTRL_TX_NEGEDGE]        = tx_negedge;
        ctrl_rd[CTRL_LSB_FIRST]         = lsb_first;
        ctrl_rd[CTRL_IE_RX]             = ie_rx;
        ctrl_rd[CTRL_IE_ERR]            = ie_err;
        status_rd                       = '0;
        status_rd[STAT_RX_EMPTY]        = rx_empty;
        status_rd[STAT_RX_FULL]         = rx_full;
        status_rd[STAT_TX_EMPTY]        = tx_empty;
        status_rd[STAT_TX_FULL]         = tx_full;
        status_rd[STAT_RX_OVERRUN]      = rx_overrun;
        status_rd[STAT_TX_UNDERRUN]     = tx_underrun;
        status_rd[STAT_BUSY]            = busy;
        case (reg_sel)
            REG_RXDATA: rd_mux = rx_empty ? '0 : rx_dout;
            REG_CTRL:   rd_mux = ctrl_rd;
            REG_STATUS: rd_mux = status_rd;
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_ack_o    <= 1'b0;
            wb_err_o    <= 1'b0;
            wb_dat_o    <= '0;
            wb_int_o    <= 1'b0;
            ctrl_len    <= '0;
            rx_negedge  <= 1'b0;
            tx_negedge  <= 1'b0;
            lsb_first   <= 1'b0;
            ie_rx       <= 1'b0;
            ie_err      <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            wb_ack_o <= acc_start & adr_ok;
            wb_err_o <= acc_start & ~adr_ok;
            wb_dat_o <= rd_go ? rd_mux : '0;
            if (wr_go && reg_sel == REG_CTRL && !busy) begin
                if (wb_sel_i[0]) ctrl_len <= wb_dat_i[CTRL_CHAR_LEN +: CLEN_W];
                if (wb_sel_i[1]) begin
                    rx_negedge <= wb_dat_i[CTRL_RX_NEGEDGE];
                    tx_negedge <= wb_dat_i[CTRL_TX_NEGEDGE];
                    lsb_first  <= wb_dat_i[CTRL_LSB_FIRST];
                    ie_rx      <= wb_dat_i[CTRL_IE_RX];
                    ie_err     <= wb_dat_i[CTRL_IE_ERR];
                end
            end
            // A new error event wins over a same-cycle W1C clear
            rx_overrun <= (rx_overrun & ~(wr_go && reg_sel == REG_STATUS && wb_dat_i[STAT_RX_OVERRUN]))
                          | (rx_done & rx_full & ~rx_pop);
            tx_underrun <= (tx_underrun & ~(wr_go && reg_sel == REG_STATUS && wb_dat_i[STAT_TX_UNDERRUN]))
                           | ((state == LOAD) & sel_p1 & tx_empty);
            wb_int_o <= (ie_rx & ~rx_empty) | (ie_err & (rx_overrun | tx_underrun));
        end
    end

    spi_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .push     (rx_done),
        .din      (rx_nxt),
        .pop      (rx_pop),
        .dout     (rx_dout),
        .full     (rx_full),
        .empty    (rx_empty)
    );

    spi_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .push     (tx_push),
        .din      (wb_dat_i),
        .pop      (tx_pop),
        .dout     (tx_dout),
        .full     (tx_full),
        .empty    (tx_empty)
    );

endmodule
